keypad_encoder: RTL and testbench

- Scans a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes each accepted keypress into an 8-bit code.
- Produces the data stream consumed by the keyboard decoder stage, which feeds the UART transmit path.
- The '#' key encodes to the reserved send code 8'h46. All other keys encode to character data.

---
 rtl/keypad_encoder.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_encoder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low matrix keypad, synchronises and
// debounces the row returns, and emits one 8-bit code per accepted press.
// The '#' key produces the reserved send code 8'h46.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held;
// the send key never repeats). Without it exactly one strobe per press.
module keypad_encoder #(
  parameter int SCAN_DIV     = 1000,     // cycles per column before sampling
  parameter int DEBOUNCE_CNT = 20000,    // stable cycles to accept press/release
  parameter int REPEAT_DLY   = 5000000   // auto-repeat period
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       busy
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_e;

  // Reject parameter values the counters cannot honour.
  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 2 || REPEAT_DLY < 2) begin : g_param_check
    $error("keypad_encoder: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [3:0]    sync1_q, row_s_q;
  // The column index also serves as the captured key column: it is frozen
  // outside SCAN, so col_out stays on the pressed key's column.
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
  // Shared by DEBOUNCE (press stability) and HOLD (release stability).
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    key_row_q, key_row_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_DLY - 1);
  localparam logic [7:0]    SEND_CODE = 8'h46;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Lowest-index active-low row in a captured pattern.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  // Key legend: row-major, column 0..3 left to right.
  function automatic logic [7:0] key_code(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    return 8'h31;  // '1'
      4'h1:    return 8'h32;  // '2'
      4'h2:    return 8'h33;  // '3'
      4'h3:    return 8'h41;  // 'A'
      4'h4:    return 8'h34;  // '4'
      4'h5:    return 8'h35;  // '5'
      4'h6:    return 8'h36;  // '6'
      4'h7:    return 8'h42;  // 'B'
      4'h8:    return 8'h37;  // '7'
      4'h9:    return 8'h38;  // '8'
      4'hA:    return 8'h39;  // '9'
      4'hB:    return 8'h43;  // 'C'
      4'hC:    return 8'h2A;  // '*'
      4'hD:    return 8'h30;  // '0'
      4'hE:    return 8'h46;  // '#' send
      default: return 8'h44;  // 'D'
    endcase
  endfunction

  // Next-state and output decode for the scan/debounce/emit/hold sequence.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    scan_cnt_d = scan_cnt_q;
    deb_cnt_d  = deb_cnt_q;
    key_row_d  = key_row_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    unique case (state_q)
      SCAN: begin
        if (scan_cnt_q == SCAN_LAST) begin
          scan_cnt_d = '0;
          if (row_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            key_row_d = row_s_q;
            busy_d    = 1'b1;
            deb_cnt_d = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (row_s_q != key_row_q) begin
          busy_d     = 1'b0;
          scan_cnt_d = '0;
          deb_cnt_d  = '0;
          state_d    = SCAN;
        end else if (deb_cnt_q == DEB_LAST) begin
          // Outputs are registered, so loading them here makes them visible
          // during the EMIT cycle itself.
          deb_cnt_d = '0;
          data_d    = key_code(lowest_low_row(key_row_q), col_idx_q);
          valid_d   = 1'b1;
          state_d   = EMIT;
        end else begin
          deb_cnt_d = deb_cnt_q + 1'b1;
        end
      end

      EMIT: begin
        deb_cnt_d = '0;
        state_d   = HOLD;
`ifdef KEYPAD_REPEAT_EN
        // The EMIT cycle counts toward the first repeat interval.
        rep_cnt_d = RW'(1);
`endif
      end

      HOLD: begin
        if (row_s_q == 4'hF) begin
          if (deb_cnt_q == DEB_LAST) begin
            busy_d     = 1'b0;
            col_idx_d  = col_idx_q + 2'd1;
            scan_cnt_d = '0;
            deb_cnt_d  = '0;
            state_d    = SCAN;
          end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
          end
        end else begin
          deb_cnt_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (row_s_q == key_row_q && data_q != SEND_CODE) begin
          if (rep_cnt_q == REP_LAST) begin
            rep_cnt_d = '0;
            valid_d   = 1'b1;
          end else begin
            rep_cnt_d = rep_cnt_q + 1'b1;
          end
        end else begin
          rep_cnt_d = '0;
        end
`endif
      end

      default: state_d = SCAN;
    endcase
  end

  // Synchroniser, state and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: synchroniser flops reset to the idle (all released) level so no
      // phantom press is seen while they refill after reset.
      sync1_q    <= 4'hF;
      row_s_q    <= 4'hF;
      state_q    <= SCAN;
      col_idx_q  <= '0;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      key_row_q  <= 4'hF;
      data_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      sync1_q    <= row_in;
      row_s_q    <= sync1_q;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      scan_cnt_q <= scan_cnt_d;
      deb_cnt_q  <= deb_cnt_d;
      key_row_q  <= key_row_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
    end
  end

  assign col_out = ~(4'b0001 << col_idx_q);
  assign oData   = data_q;
  assign oValid  = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: drives a behavioural 4x4 keypad against keypad_encoder
// and checks codes, strobe counts, latency, release timing and reset.
`timescale 1ns/1ps
module tb_keypad_encoder;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_DLY   = 32;
`ifdef KEYPAD_REPEAT_EN
  localparam bit REPEAT_ON = 1'b1;
`else
  localparam bit REPEAT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] oData;
  logic       oValid;
  logic       busy;

  // pressed[c] bit r = key at row r, column c is physically held down.
  logic [3:0] pressed [4];

  int checks = 0;
  int errors = 0;

  logic [7:0]  strobe_data [$];
  int unsigned strobe_cyc  [$];
  int unsigned cyc = 0;
  int unsigned busy_rise_cyc = 0;
  logic        prev_valid = 1'b0;
  logic        prev_busy  = 1'b0;
  logic [7:0]  prev_data  = 8'h00;

  keypad_encoder #(
    .SCAN_DIV    (SCAN_DIV),
    .DEBOUNCE_CNT(DEBOUNCE_CNT),
    .REPEAT_DLY  (REPEAT_DLY)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .row_in (row_in),
    .col_out(col_out),
    .oData  (oData),
    .oValid (oValid),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a driven (low) column pulls down the rows of held keys.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      if (!col_out[c]) row_in = row_in & ~pressed[c];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference encoding from the printed key legend; '#' maps to the send code.
  function automatic logic [7:0] model_code(input logic [3:0] rows, input int c);
    string legend;
    int    r;
    byte   ch;
    legend = "123A456B789C*0#D";
    r = 0;
    for (int i = 3; i >= 0; i--) if (rows[i]) r = i;
    ch = legend.getc(r * 4 + c);
    return (ch == 8'h23) ? 8'h46 : 8'(ch);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Cycle monitor: records strobes and checks the invariant output rules.
  always @(negedge clk) begin
    if (!rst) begin
      check("col_one_low", 32'($countones(~col_out)), 1);
      if (oValid) begin
        check("strobe_back_to_back", {31'b0, prev_valid}, 0);
        strobe_data.push_back(oData);
        strobe_cyc.push_back(cyc);
      end
      if (oData != prev_data) check("data_changes_only_on_strobe", {31'b0, oValid}, 1);
      if (busy && !prev_busy) busy_rise_cyc <= cyc;
    end
    prev_valid <= oValid;
    prev_busy  <= busy;
    prev_data  <= oData;
  end

  task automatic release_all();
    for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
  endtask

  task automatic wait_strobe(input int n_before, input string tag);
    int k;
    k = 0;
    while (strobe_data.size() <= n_before && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_strobe_timeout"}, {31'b0, strobe_data.size() > n_before}, 1);
  endtask

  // Release everything and time busy falling: two synchroniser stages plus
  // DEBOUNCE_CNT stable released cycles.
  task automatic release_and_time(input string tag);
    int k;
    k = 0;
    release_all();
    do begin
      @(posedge clk); #1;
      k++;
    end while (busy && k < 100);
    check({tag, "_release_cycles"}, k, DEBOUNCE_CNT + 2);
  endtask

  task automatic run_key(input logic [3:0] rows, input int c, input int hold,
                         input bit bounce, input string tag);
    int         n0;
    int         exp_n;
    logic [7:0] exp;
    n0  = strobe_data.size();
    exp = model_code(rows, c);
    pressed[c] = rows;
    if (bounce) begin
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (i % 3 == 2) pressed[c] = pressed[c] ^ rows;
      end
      check({tag, "_no_strobe_in_bounce"}, strobe_data.size() - n0, 0);
      pressed[c] = rows;
    end
    wait_strobe(n0, tag);
    if (strobe_data.size() > n0) begin
      check({tag, "_code"}, strobe_data[n0], exp);
      check({tag, "_latency"}, int'(strobe_cyc[n0] - busy_rise_cyc), DEBOUNCE_CNT);
    end
    check({tag, "_busy_held"}, {31'b0, busy}, 1);
    repeat (hold) begin @(posedge clk); #1; end
    release_and_time(tag);
    // Key stays visible to the design for hold+3 cycles after the strobe
    // was seen, so repeats land every REPEAT_DLY within that window.
    exp_n = 1 + ((REPEAT_ON && exp != 8'h46) ? (hold + 3) / REPEAT_DLY : 0);
    check({tag, "_strobe_count"}, strobe_data.size() - n0, exp_n);
    for (int k = n0 + 1; k < strobe_data.size(); k++) begin
      check({tag, "_repeat_code"}, strobe_data[k], exp);
      check({tag, "_repeat_gap"}, int'(strobe_cyc[k] - strobe_cyc[k-1]), REPEAT_DLY);
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  initial begin
    int n0;
    rst = 1'b1;
    release_all();
    repeat (3) @(posedge clk);
    #1;
    check("reset_col_out", col_out, 4'b1110);
    check("reset_data", oData, 8'h00);
    check("reset_valid", {31'b0, oValid}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    rst = 1'b0;

    run_key(4'b0010, 1, 6, 1'b0, "key5");
    run_key(4'b1000, 2, 100, 1'b0, "send_hold");
    run_key(4'b0001, 3, 100, 1'b0, "hold_A");
    run_key(4'b0100, 1, 4, 1'b1, "bounce8");

    // Rows 1 and 3 in column 0, then '9' pressed while the first is held.
    n0 = strobe_data.size();
    pressed[0] = 4'b1010;
    wait_strobe(n0, "multi");
    if (strobe_data.size() > n0) check("multi_code", strobe_data[n0], 8'h34);
    pressed[2] = 4'b0100;
    repeat (10) begin @(posedge clk); #1; end
    check("multi_ignored_in_hold", strobe_data.size() - n0, 1);
    pressed[0] = 4'b0000;
    wait_strobe(n0 + 1, "multi9");
    if (strobe_data.size() > n0 + 1) check("multi9_code", strobe_data[n0+1], 8'h39);
    release_and_time("multi9");
    check("multi_strobe_count", strobe_data.size() - n0, 2);
    repeat (5) begin @(posedge clk); #1; end

    // Asynchronous reset in the middle of HOLD.
    n0 = strobe_data.size();
    pressed[0] = 4'b0001;
    wait_strobe(n0, "rst_hold");
    repeat (3) begin @(posedge clk); #1; end
    check("rst_hold_busy_before", {31'b0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_col_out", col_out, 4'b1110);
    check("rst_async_data", oData, 8'h00);
    check("rst_async_valid", {31'b0, oValid}, 0);
    check("rst_async_busy", {31'b0, busy}, 0);
    release_all();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end

    // Randomised presses: any column, any non-empty row pattern.
    for (int i = 0; i < 12; i++) begin
      int         c;
      logic [3:0] rows;
      int         hold;
      bit         bounce;
      c      = $urandom_range(0, 3);
      rows   = 4'($urandom_range(1, 15));
      hold   = $urandom_range(0, 20);
      bounce = 1'($urandom_range(0, 1));
      run_key(rows, c, hold, bounce, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
